// File: rtl/key_conditioner.sv
// key_conditioner: turns a raw active-low pushbutton into a clean one-cycle
// pulse per accepted press, with optional auto-repeat while the key is held.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic pulse,
    output logic level,
    output logic held
);

    localparam int MAX_DH     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        REPEAT,
        DB_RELEASE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             s1;
    logic             s2;
    logic             pulse_req;
    logic             level_next;
    logic             held_next;

    // Two-flop synchronizer; s2 is the only view of the key the FSM gets.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= ~btn_n;
            s2 <= s1;
        end
    end

    // Masking with the current pulse keeps pulses one cycle apart even when
    // every interval is a single cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pulse <= pulse_req & ~pulse;
            level <= level_next;
            held  <= held_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        pulse_req  = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (s2) begin
                    state_next = DB_PRESS;
                end
            end

            DB_PRESS: begin
                if (!s2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    pulse_req  = 1'b1;
                end
            end

            // Without auto-repeat the hold timer parks at its last value.
            PRESSED: begin
                if (!s2) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end else if (cnt == HOLD_LAST) begin
                    if (REPEAT_EN) begin
                        state_next = REPEAT;
                        cnt_next   = '0;
                        pulse_req  = 1'b1;
                    end else begin
                        cnt_next = cnt;
                    end
                end
            end

            REPEAT: begin
                if (!s2) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_next  = '0;
                    pulse_req = 1'b1;
                end
            end

            DB_RELEASE: begin
                if (s2) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        level_next = (state_next == PRESSED) || (state_next == REPEAT) ||
                     (state_next == DB_RELEASE);
        held_next  = (state_next == REPEAT);
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of the key conditioner; expected pulse
// cycles are queued when a key action is driven and popped as pulses appear.
module tb_key_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_n;
    logic btn2_n;
    logic pulse, level, held;
    logic pulse2, level2, held2;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int exp_q2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP),
        .REPEAT_EN      (1'b1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_n  (btn_n),
        .pulse  (pulse),
        .level  (level),
        .held   (held)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP),
        .REPEAT_EN      (1'b0)
    ) dut_norep (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_n  (btn2_n),
        .pulse  (pulse2),
        .level  (level2),
        .held   (held2)
    );

    // Every observed pulse must match the oldest expected pulse cycle.
    always @(negedge clk) begin
        int want;
        if (pulse !== 1'b0) begin
            want = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            tests++;
            assert (cyc === want) else begin
                fails++;
                $error("[TB] FAIL pulse_cycle: observed %0d expected %0d", cyc, want);
            end
        end
    end

    always @(negedge clk) begin
        int want;
        if (pulse2 !== 1'b0) begin
            want = (exp_q2.size() != 0) ? exp_q2.pop_front() : -1;
            tests++;
            assert (cyc === want) else begin
                fails++;
                $error("[TB] FAIL pulse2_cycle: observed %0d expected %0d", cyc, want);
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic val, output int first_edge);
        btn_n      = val;
        first_edge = cyc + 1;
    endtask

    initial begin
        int e0;
        int r;
        int held_hi;

        btn_n   = 1'b1;
        btn2_n  = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_pulse", 32'(pulse), 0);
        check_output("reset_level", 32'(level), 0);
        check_output("reset_held",  32'(held),  0);
        check_output("reset_level2", 32'(level2), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_output("idle_level", 32'(level), 0);

        // Clean press held 40 cycles: press pulse, then auto-repeat.
        apply_stimulus(1'b0, e0);
        exp_q.push_back(e0 + 6);
        for (int t = e0 + 16; t <= e0 + 40; t += REP) exp_q.push_back(t);
        wait_to(e0 + 5);  check_output("press_level_before", 32'(level), 0);
        wait_to(e0 + 6);  check_output("press_level_after",  32'(level), 1);
        wait_to(e0 + 15); check_output("held_before", 32'(held), 0);
        wait_to(e0 + 16); check_output("held_after",  32'(held), 1);
        wait_to(e0 + 39); btn_n = 1'b1;
        wait_to(e0 + 41); check_output("held_release_early", 32'(held), 1);
        wait_to(e0 + 42); check_output("held_release", 32'(held), 0);
        check_output("level_in_release", 32'(level), 1);
        wait_to(e0 + 45); check_output("release_level_before", 32'(level), 1);
        wait_to(e0 + 46); check_output("release_level_after",  32'(level), 0);
        wait_to(e0 + 50); check_output("repeat_queue_empty", 32'(exp_q.size()), 0);

        // Bounce on press: low 2, high 1, then steady low.
        btn_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_n = 1'b1;
        @(negedge clk);
        apply_stimulus(1'b0, e0);
        exp_q.push_back(e0 + 6);
        wait_to(e0 + 5);  check_output("bounce_level_before", 32'(level), 0);
        wait_to(e0 + 7);  btn_n = 1'b1;
        wait_to(e0 + 13); check_output("bounce_release_before", 32'(level), 1);
        wait_to(e0 + 14); check_output("bounce_release_after",  32'(level), 0);
        wait_to(e0 + 18); check_output("bounce_queue_empty", 32'(exp_q.size()), 0);

        // Release bounce back to pressed restarts the hold timer.
        apply_stimulus(1'b0, e0);
        exp_q.push_back(e0 + 6);
        exp_q.push_back(e0 + 22);
        exp_q.push_back(e0 + 25);
        wait_to(e0 + 7); btn_n = 1'b1;
        wait_to(e0 + 9); btn_n = 1'b0;
        for (int t = e0 + 9; t <= e0 + 14; t++) begin
            wait_to(t);
            check_output("rebounce_level", 32'(level), 1);
        end
        wait_to(e0 + 21); check_output("rebounce_held_before", 32'(held), 0);
        wait_to(e0 + 22); check_output("rebounce_held_after",  32'(held), 1);
        wait_to(e0 + 23); btn_n = 1'b1;
        wait_to(e0 + 29); check_output("rebounce_rel_before", 32'(level), 1);
        wait_to(e0 + 30); check_output("rebounce_rel_after",  32'(level), 0);
        check_output("rebounce_held_end", 32'(held), 0);
        wait_to(e0 + 34); check_output("rebounce_queue_empty", 32'(exp_q.size()), 0);

        // Reset asserted mid-repeat, released with the key still down.
        apply_stimulus(1'b0, e0);
        exp_q.push_back(e0 + 6);
        exp_q.push_back(e0 + 16);
        wait_to(e0 + 16);
        check_output("pre_reset_held", 32'(held), 1);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_reset_pulse", 32'(pulse), 0);
        check_output("async_reset_level", 32'(level), 0);
        check_output("async_reset_held",  32'(held),  0);
        repeat (2) @(negedge clk);
        check_output("reset_queue_empty", 32'(exp_q.size()), 0);
        reset_n = 1'b1;
        r = cyc;
        exp_q.push_back(r + 7);
        wait_to(r + 6);  check_output("post_reset_level_before", 32'(level), 0);
        wait_to(r + 7);  check_output("post_reset_level_after",  32'(level), 1);
        wait_to(r + 8);  btn_n = 1'b1;
        wait_to(r + 16); check_output("post_reset_released", 32'(level), 0);
        check_output("post_reset_queue_empty", 32'(exp_q.size()), 0);

        // No auto-repeat: one pulse for a long hold, held never rises.
        btn2_n = 1'b0;
        e0 = cyc + 1;
        exp_q2.push_back(e0 + 6);
        held_hi = 0;
        for (int t = e0; t <= e0 + 99; t++) begin
            wait_to(t);
            if (held2 !== 1'b0) held_hi++;
        end
        check_output("norep_held_cycles", 32'(held_hi), 0);
        check_output("norep_level_held", 32'(level2), 1);
        btn2_n = 1'b1;
        wait_to(e0 + 105); check_output("norep_release_before", 32'(level2), 1);
        wait_to(e0 + 106); check_output("norep_release_after",  32'(level2), 0);
        wait_to(e0 + 110);
        check_output("norep_queue_empty", 32'(exp_q2.size()), 0);
        check_output("main_queue_quiet", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Conditions a raw active-low pushbutton (the board's `next_n` key) into a clean single-cycle `pulse` that drives the memory-stepping FSM's `next` input, replacing the plain inversion used today. Stages: two-flop synchronizer, counter-based debouncer on press and release, optional auto-repeat while held. Without this block, one physical press steps the FSM many addresses, because the FSM advances on every cycle `next` is high and contacts bounce for milliseconds.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: cycles the synchronized input must stay stable to accept a press or release (10 ms at 50 MHz); must be ≥ 1.
- `HOLD_CYCLES`, 25000000: cycles from accepted press to first auto-repeat pulse; must be ≥ 1.
- `REPEAT_CYCLES`, 5000000: cycles between subsequent auto-repeat pulses; must be ≥ 1.
- `REPEAT_EN`, 1: 1 enables auto-repeat; 0 gives exactly one pulse per press.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_n`  in  1  raw key, active-low, asynchronous to `clk`.
- `pulse`  out  1  registered; high for exactly one cycle per accepted press or repeat.
- `level`  out  1  registered; debounced "key pressed" level.
- `held`  out  1  registered; high while in auto-repeat.

## Operation
- Synchronizer: `s1 <= ~btn_n; s2 <= s1`. Both reset to 0 (not pressed). All FSM logic uses `s2` only.
- One shared counter `cnt`, width `$clog2` of the largest parameter + 1, reset to 0, cleared on every state change.
- States (reset → IDLE):
  - IDLE: `level`=0. If `s2`=1 → DB_PRESS.
  - DB_PRESS: if `s2`=0 → IDLE (bounce rejected, no pulse). Otherwise `cnt++`. When `cnt`==DEBOUNCE_CYCLES-1 → PRESSED, with `pulse`=1 and `level`=1.
  - PRESSED: if `s2`=0 → DB_RELEASE. Otherwise `cnt++`. When `cnt`==HOLD_CYCLES-1 and REPEAT_EN=1 → REPEAT, with `pulse`=1 and `held`=1. When REPEAT_EN=0, `cnt` saturates and the block stays in PRESSED.
  - REPEAT: if `s2`=0 → DB_RELEASE (`held`→0). Otherwise `cnt++`. When `cnt`==REPEAT_CYCLES-1, `pulse`=1 and `cnt`=0 (stay in REPEAT).
  - DB_RELEASE: `level` stays 1, `held`=0. If `s2`=1 → PRESSED (hold timer restarts from 0, no pulse). Otherwise `cnt++`. When `cnt`==DEBOUNCE_CYCLES-1 → IDLE, `level`=0.
- `pulse` is never high on two consecutive cycles, even with all parameters = 1.

## Timing
- Reset values: `pulse`=0, `level`=0, `held`=0, state=IDLE, `cnt`=0, `s1`=`s2`=0. Reset takes effect immediately when asserted, mid-operation included. No pulse is emitted on reset deassertion, even if the key is already held; with the key held, the press is debounced afresh from IDLE.
- Edge E0 is the first rising edge that samples `btn_n`=0, with `btn_n` then held low.
  - `s2`=1 after E1; the FSM enters DB_PRESS at E2.
  - `pulse` and `level` rise after edge E(DEBOUNCE_CYCLES+2).
  - `pulse` falls one edge later.
- First repeat pulse: exactly HOLD_CYCLES cycles after the press pulse. Later repeats: every REPEAT_CYCLES cycles.
- Release: with `btn_n` high from sampling edge F0, `level` falls after edge F(DEBOUNCE_CYCLES+2).
- Any single-cycle glitch on `btn_n` resets the debounce in progress. It never produces a pulse unless `s2` holds steady for DEBOUNCE_CYCLES.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, REPEAT_EN=1 unless noted.
- Reset: assert `reset_n`=0 mid-REPEAT → `pulse`, `level`, `held` all 0 immediately; release reset with key held → no pulse until 6 edges later.
- Clean press: `btn_n` low from E0 → `pulse`=1 only in the cycle after E6, `level`=1 from E6.
- Bounce on press: `btn_n` low 2 cycles, high 1 cycle, then low steady from E0' → exactly one pulse, after E0'+6.
- Auto-repeat: hold 40 cycles → pulses at E6, E16, E19, E22, …; `held`=1 from E16.
- Release bounce back to pressed: from PRESSED, `btn_n` high 2 cycles then low again → `level` stays 1, no pulse, next repeat pulse 10 cycles after re-entering PRESSED.
- REPEAT_EN=0, key held 100 cycles → exactly one pulse; `held` stays 0; release → `level` falls 6 edges after the release sample.
